// File: rtl/ysyx_24100006_csr_pkg.sv
// Shared encodings for the CSR sequencer and the CSR register file:
// instruction ops, sequencer states and machine-mode CSR addresses.
package ysyx_24100006_csr_pkg;

    localparam logic [2:0] OP_CSRRW = 3'd1;
    localparam logic [2:0] OP_CSRRS = 3'd2;
    localparam logic [2:0] OP_CSRRC = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_TRAP  = 3'd3;
    localparam logic [2:0] ST_RET   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

endpackage

// File: rtl/ysyx_24100006_csr_alu.sv
// Combinational read-modify-write datapath: forms the CSR write value
// from the old CSR contents and the rs1 operand.
module ysyx_24100006_csr_alu
    import ysyx_24100006_csr_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] old,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    output logic [DATA_WIDTH-1:0] wdata
);

    always_comb begin
        wdata = '0;
        case (op)
            OP_CSRRW: wdata = rs1_val;
            OP_CSRRS: wdata = old | rs1_val;
            OP_CSRRC: wdata = old & ~rs1_val;
            default:  wdata = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24100006_csr_ctrl.sv
// Multi-cycle sequencer for CSRRW/CSRRS/CSRRC/ECALL/MRET between decode and
// the CSR register file, with valid/ready handshakes on both sides.
module ysyx_24100006_csr_ctrl
    import ysyx_24100006_csr_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_csr_addr,
    input  logic [DATA_WIDTH-1:0] in_rs1_val,
    input  logic                  in_rs1_zero,
    output logic [ADDR_WIDTH-1:0] csr_raddr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic [ADDR_WIDTH-1:0] csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  csr_wen,
    output logic                  csr_irq,
    input  logic [DATA_WIDTH-1:0] csr_mtvec,
    input  logic [DATA_WIDTH-1:0] csr_mepc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rd_data,
    output logic                  out_redirect,
    output logic [DATA_WIDTH-1:0] out_redirect_pc
);

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rs1_q;
    logic                  rs1_zero_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic                  redirect_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;
    logic [DATA_WIDTH-1:0] alu_wdata;

    ysyx_24100006_csr_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op     (op_q),
        .old    (old_q),
        .rs1_val(rs1_q),
        .wdata  (alu_wdata)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_csr_op(in_op))       state_next = ST_READ;
                    else if (in_op == OP_ECALL) state_next = ST_TRAP;
                    else if (in_op == OP_MRET)  state_next = ST_RET;
                    else                        state_next = ST_DONE;
                end
            end
            ST_READ:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_DONE;
            ST_TRAP:  state_next = ST_DONE;
            ST_RET:   state_next = ST_DONE;
            ST_DONE:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Result fields are cleared on accept so ECALL/MRET/illegal ops return rd=0
    // and only trap/return ops leave a redirect behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_q          <= '0;
            pc_q          <= '0;
            addr_q        <= '0;
            rs1_q         <= '0;
            rs1_zero_q    <= 1'b0;
            old_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q          <= in_op;
                        pc_q          <= in_pc;
                        addr_q        <= in_csr_addr;
                        rs1_q         <= in_rs1_val;
                        rs1_zero_q    <= in_rs1_zero;
                        old_q         <= '0;
                        redirect_q    <= 1'b0;
                        redirect_pc_q <= '0;
                    end
                end
                ST_READ: old_q <= csr_rdata;
                ST_TRAP: begin
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= csr_mtvec;
                end
                ST_RET: begin
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= csr_mepc;
                end
                default: ;
            endcase
        end
    end

    // CSRRS/CSRRC with rs1=x0 are pure reads and must not disturb side-effecting CSRs.
    always_comb begin
        csr_wen   = (state == ST_WRITE) && !(rs1_zero_q && (op_q != OP_CSRRW));
        csr_irq   = (state == ST_TRAP);
        csr_wdata = '0;
        if (state == ST_WRITE)     csr_wdata = alu_wdata;
        else if (state == ST_TRAP) csr_wdata = pc_q;
    end

    assign csr_raddr       = addr_q;
    assign csr_waddr       = addr_q;
    assign in_ready        = (state == ST_IDLE);
    assign out_valid       = (state == ST_DONE);
    assign out_rd_data     = old_q;
    assign out_redirect    = redirect_q;
    assign out_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ysyx_24100006_csr_ctrl.sv
// Scoreboard bench for the CSR sequencer, driving it against a small
// behavioural model of the machine-mode CSR register file.
module tb_ysyx_24100006_csr_ctrl;
    import ysyx_24100006_csr_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_pc;
    logic [11:0] in_csr_addr;
    logic [31:0] in_rs1_val;
    logic        in_rs1_zero;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic        csr_irq;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd_data;
    logic        out_redirect;
    logic [31:0] out_redirect_pc;

    typedef struct {
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        int          lat;
        int          wen_n;
        int          irq_n;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wen_cnt = 0;
    int   irq_cnt = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] irq_wdata  = '0;

    logic [31:0] mstatus_m = 32'h0000_1800;
    logic [31:0] mtvec_m   = 32'h0;
    logic [31:0] mepc_m    = 32'h0000_00F0;
    logic [31:0] mcause_m  = 32'h0;

    ysyx_24100006_csr_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_pc          (in_pc),
        .in_csr_addr    (in_csr_addr),
        .in_rs1_val     (in_rs1_val),
        .in_rs1_zero    (in_rs1_zero),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_wen        (csr_wen),
        .csr_irq        (csr_irq),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rd_data    (out_rd_data),
        .out_redirect   (out_redirect),
        .out_redirect_pc(out_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model; the read-only ID registers read as zero and drop writes.
    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS: csr_rdata = mstatus_m;
            CSR_MTVEC:   csr_rdata = mtvec_m;
            CSR_MEPC:    csr_rdata = mepc_m;
            CSR_MCAUSE:  csr_rdata = mcause_m;
            default:     csr_rdata = '0;
        endcase
    end
    assign csr_mtvec = mtvec_m;
    assign csr_mepc  = mepc_m;

    always @(posedge clk) begin
        if (csr_irq) begin
            mepc_m   <= csr_wdata;
            mcause_m <= 32'd11;
        end else if (csr_wen) begin
            case (csr_waddr)
                CSR_MSTATUS: mstatus_m <= csr_wdata;
                CSR_MTVEC:   mtvec_m   <= csr_wdata;
                CSR_MEPC:    mepc_m    <= csr_wdata;
                CSR_MCAUSE:  mcause_m  <= csr_wdata;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (csr_wen) begin
            wen_cnt    = wen_cnt + 1;
            last_wdata = csr_wdata;
        end
        if (csr_irq) begin
            irq_cnt   = irq_cnt + 1;
            irq_wdata = csr_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic [2:0]  op,
        input logic [31:0] pc,
        input logic [11:0] addr,
        input logic [31:0] rs1,
        input logic        rz,
        input logic [31:0] exp_rd,
        input logic        exp_redir,
        input logic [31:0] exp_rpc,
        input int          exp_lat,
        input int          exp_wen,
        input int          exp_irq,
        input logic [31:0] exp_wdata,
        input int          hold
    );
        exp_t e;
        int   lat;
        int   w0;
        int   i0;
        sb.push_back('{exp_rd, exp_redir, exp_rpc, exp_lat, exp_wen, exp_irq, exp_wdata});
        @(negedge clk);
        checkOutput("in_ready_idle", in_ready, 1);
        out_ready   = (hold == 0);
        in_valid    = 1'b1;
        in_op       = op;
        in_pc       = pc;
        in_csr_addr = addr;
        in_rs1_val  = rs1;
        in_rs1_zero = rz;
        w0 = wen_cnt;
        i0 = irq_cnt;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat = lat + 1;
            in_valid = 1'b0;
        end while (!out_valid && lat < 20);
        checkOutput("out_valid_timeout", out_valid, 1);
        e = sb.pop_front();
        checkOutput("latency", lat, e.lat);
        checkOutput("rd_data", out_rd_data, e.rd);
        checkOutput("redirect", out_redirect, e.redir);
        checkOutput("redirect_pc", out_redirect_pc, e.rpc);
        checkOutput("wen_pulses", wen_cnt - w0, e.wen_n);
        checkOutput("irq_pulses", irq_cnt - i0, e.irq_n);
        if (e.wen_n > 0) checkOutput("wen_wdata", last_wdata, e.wdata);
        if (e.irq_n > 0) checkOutput("irq_wdata", irq_wdata, e.wdata);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_redirect_pc", out_redirect_pc, e.rpc);
            checkOutput("hold_no_strobe", {csr_wen, csr_irq}, 0);
        end
        if (hold > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("idle_after", in_ready, 1);
        checkOutput("valid_after", out_valid, 0);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_op       = '0;
        in_pc       = '0;
        in_csr_addr = '0;
        in_rs1_val  = '0;
        in_rs1_zero = 1'b0;
        out_ready   = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_strobes", {csr_wen, csr_irq}, 0);
        checkOutput("rst_rd_data", out_rd_data, 0);
        checkOutput("rst_redirect", {out_redirect, out_redirect_pc}, 0);
        checkOutput("rst_addr", {csr_raddr, csr_waddr}, 0);
        checkOutput("rst_wdata", csr_wdata, 0);
        reset = 1'b0;

        //            op        pc            addr     rs1           rz    rd            rdr   rpc           lat wen irq wdata         hold
        applyStimulus(OP_CSRRW, 32'h0,        12'h305, 32'h80000100, 1'b0, 32'h0,        1'b0, 32'h0,        3,  1,  0,  32'h80000100, 0);
        applyStimulus(OP_CSRRS, 32'h0,        12'h305, 32'h0000FFFF, 1'b1, 32'h80000100, 1'b0, 32'h0,        3,  0,  0,  32'h0,        0);
        applyStimulus(OP_CSRRS, 32'h0,        12'h341, 32'h0000000F, 1'b0, 32'h000000F0, 1'b0, 32'h0,        3,  1,  0,  32'h000000FF, 0);
        applyStimulus(OP_CSRRC, 32'h0,        12'h341, 32'h000000FF, 1'b0, 32'h000000FF, 1'b0, 32'h0,        3,  1,  0,  32'h00000000, 0);
        applyStimulus(OP_CSRRS, 32'h0,        12'h300, 32'h0,        1'b1, 32'h00001800, 1'b0, 32'h0,        3,  0,  0,  32'h0,        0);
        applyStimulus(OP_ECALL, 32'h80000040, 12'h0,   32'h0,        1'b0, 32'h0,        1'b1, 32'h80000100, 2,  0,  1,  32'h80000040, 0);
        applyStimulus(OP_CSRRS, 32'h0,        12'h342, 32'h0,        1'b1, 32'd11,       1'b0, 32'h0,        3,  0,  0,  32'h0,        0);
        applyStimulus(OP_CSRRW, 32'h0,        12'h341, 32'h80000044, 1'b0, 32'h80000040, 1'b0, 32'h0,        3,  1,  0,  32'h80000044, 0);
        applyStimulus(OP_MRET,  32'h0,        12'h0,   32'h0,        1'b0, 32'h0,        1'b1, 32'h80000044, 2,  0,  0,  32'h0,        5);
        applyStimulus(3'd0,     32'h0,        12'h0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1,  0,  0,  32'h0,        0);
        applyStimulus(OP_CSRRW, 32'h0,        12'hF11, 32'h00001234, 1'b0, 32'h0,        1'b0, 32'h0,        3,  1,  0,  32'h00001234, 0);

        // Reset lands in the middle of a CSRRW's WRITE cycle.
        @(negedge clk);
        in_valid    = 1'b1;
        in_op       = OP_CSRRW;
        in_csr_addr = 12'h305;
        in_rs1_val  = 32'hDEADBEEF;
        in_rs1_zero = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_wen", csr_wen, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_strobes", {csr_wen, csr_irq}, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_rd_data", out_rd_data, 0);
        checkOutput("mid_rst_addr_wdata", {csr_raddr, csr_waddr, csr_wdata}, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mtvec_after_rst", mtvec_m, 32'h80000100);

        applyStimulus(3'd6,     32'h0,        12'h0,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1,  0,  0,  32'h0,        0);
        applyStimulus(OP_CSRRS, 32'h0,        12'h305, 32'h0,        1'b1, 32'h80000100, 1'b0, 32'h0,        3,  0,  0,  32'h0,        0);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_csr_ctrl.md
# ysyx_24100006_csr_ctrl

Multi-cycle sequencer between the decode stage and the CSR register file: it accepts one system instruction at a time (CSRRW/CSRRS/CSRRC/ECALL/MRET) over a valid/ready handshake. It performs the CSR read-modify-write or trap/return sequence through the CSR file's read/write/irq ports. It then presents the rd result and any PC redirect downstream over a second valid/ready handshake.

## Interface
- ADDR_WIDTH, 12, CSR address width
- DATA_WIDTH, 32, data/PC width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  high only in IDLE
- in_op  in  3  1=CSRRW 2=CSRRS 3=CSRRC 4=ECALL 5=MRET; others illegal
- in_pc  in  DATA_WIDTH  PC of the instruction
- in_csr_addr  in  ADDR_WIDTH  instr[31:20]
- in_rs1_val  in  DATA_WIDTH  rs1 operand
- in_rs1_zero  in  1  rs1 index is x0
- csr_raddr  out  ADDR_WIDTH  to CSR file read address
- csr_rdata  in  DATA_WIDTH  CSR file combinational read data
- csr_waddr / csr_wdata / csr_wen  out  ADDR_WIDTH / DATA_WIDTH / 1  CSR write port
- csr_irq  out  1  trap strobe; CSR file loads mepc<=csr_wdata, mcause<=11
- csr_mtvec, csr_mepc  in  DATA_WIDTH  live CSR values
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_rd_data  out  DATA_WIDTH  old CSR value (0 for ECALL/MRET/illegal)
- out_redirect  out  1  PC redirect required
- out_redirect_pc  out  DATA_WIDTH  redirect target

## Operation
- FSM states: IDLE, READ, WRITE, TRAP, RET, DONE.
- IDLE: in_ready=1. On in_valid, latch op, pc, addr, rs1_val, and rs1_zero.
  - ops 1–3 go to READ; op 4 goes to TRAP; op 5 goes to RET.
  - Illegal ops go to DONE with rd_data=0 and redirect=0.
- READ: csr_raddr=latched addr; register csr_rdata into old. Next state WRITE.
- WRITE: csr_waddr=addr. csr_wdata is one of:
  - RW: rs1_val
  - RS: old|rs1_val
  - RC: old&~rs1_val
- WRITE: csr_wen=1 except RS/RC with rs1_zero=1 (wen=0). Next state DONE.
- Writes to read-only or unknown CSRs are still issued; the CSR file drops them. rd_data is still the value read.
- TRAP: csr_irq=1, csr_wdata=latched pc, csr_wen=0. Register redirect_pc<=csr_mtvec and redirect<=1. Next state DONE.
- RET: register redirect_pc<=csr_mepc and redirect<=1; no CSR strobes. Next state DONE.
- DONE: out_valid=1. Outputs are held stable until out_ready; on out_ready go to IDLE.
- csr_wen and csr_irq are combinational decodes of the state. They are never both high.

## Timing
- Reset (async) values:
  - state=IDLE, in_ready=1, out_valid=0
  - csr_wen=0, csr_irq=0
  - out_rd_data=0, out_redirect=0, out_redirect_pc=0
  - csr_raddr/waddr/wdata=0
- Latency from the accept edge to out_valid high:
  - CSR ops: 3 cycles
  - ECALL/MRET: 2 cycles
  - Illegal ops: 1 cycle
- Throughput: after the DONE handshake there is one IDLE cycle, so a CSR op with out_ready tied high takes 4 cycles/op.
- in_valid while not IDLE is ignored (in_ready=0). Upstream must hold the instruction.
- Back-pressure: with out_ready low, DONE persists indefinitely with no further CSR strobes.
- A CSR write becomes visible to csr_rdata the cycle after WRITE. Back-to-back ops to the same CSR therefore read the updated value.
- Reset asserted in READ/WRITE/TRAP:
  - wen/irq drop immediately and no partial write occurs.
  - A write/irq edge coinciding with reset assertion is undefined.

## Structure
- Shared package holds the op encodings, state encodings, and CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MVENDORID 0xF11, MARCHID 0xF12). The CSR file uses the same constants.
- One natural combinational sub-module, ysyx_24100006_csr_alu, takes (op, old, rs1_val) and produces wdata.
- The rest is a single FSM plus the latch registers.

## Test plan
- CSRRW 0x305, rs1=0x80000100, out_ready=1 -> wen pulse one cycle with wdata 0x80000100; out_valid 3 cycles after accept; rd_data is the prior mtvec; the next read of mtvec returns 0x80000100.
- CSRRS 0x341 with mepc=0x0F0, rs1=0x00F; then CSRRC with rs1=0x0FF -> wdata 0x0FF then 0x000; rd_data 0x0F0 then 0x0FF.
- CSRRS 0x300 with rs1_zero=1 -> wen never asserted; rd_data 0x00001800.
- ECALL pc=0x80000040, mtvec=0x80000100 -> irq one cycle with wdata 0x80000040; out_redirect=1 to 0x80000100; afterwards mcause reads 11 and mepc reads 0x80000040.
- MRET with mepc=0x80000044, out_ready low 5 cycles -> out_valid held with stable redirect_pc 0x80000044; in_ready=0 throughout; IDLE the cycle after out_ready.
- Reset asserted during WRITE of CSRRW 0x305 -> wen low immediately; mtvec unchanged; all outputs at reset values; op 6 afterwards -> out_valid after 1 cycle, rd_data 0, no redirect.
